// File: rtl/llr_frame_loader_if.sv
// ============================================================================
// Module   : llr_frame_loader_if
// Purpose  : Channel-LLR input stream and parallel frame output bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface llr_frame_loader_if #(
    parameter int N                = 8,
    parameter int CH_W             = 8,
    parameter int LLR_INTERNAL_LEN = 6
);
    logic                            in_valid;
    logic                            in_ready;
    logic [CH_W-1:0]                 in_llr;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic [N*LLR_INTERNAL_LEN-1:0]   out_llr;
    logic                            frame_err;

    modport slave (
        input  in_valid, in_llr, in_last, out_ready,
        output in_ready, out_valid, out_llr, frame_err
    );

    modport master (
        output in_valid, in_llr, in_last, out_ready,
        input  in_ready, out_valid, out_llr, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/llr_frame_loader.sv
// ============================================================================
// Module   : llr_frame_loader
// Purpose  : Quantises channel LLRs and assembles ping-pong buffered frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module llr_frame_loader #(
    parameter int N                = 8,
    parameter int CH_W             = 8,
    parameter int SHIFT            = 1,
    parameter int LLR_INTERNAL_LEN = 6
) (
    input  logic                clk,
    input  logic                rst,
    llr_frame_loader_if.slave   bus
);
    localparam int c_cnt_w   = $clog2(N);
    localparam int c_frame_w = N * LLR_INTERNAL_LEN;
    localparam int c_sat     = 2**(LLR_INTERNAL_LEN-1) - 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(N-1);
    localparam logic signed [CH_W-1:0] c_sat_hi = CH_W'(c_sat);
    localparam logic signed [CH_W-1:0] c_sat_lo = CH_W'(-c_sat);

    logic signed [CH_W-1:0]          w_shifted;
    logic [LLR_INTERNAL_LEN-1:0]     w_quant;
    logic                            w_in_ready;
    logic                            w_out_valid;
    logic                            w_in_fire;
    logic                            w_last_slot;
    logic                            w_wr_done;
    logic                            w_rd_done;
    logic [1:0]                      w_full_nxt;
    logic [c_frame_w-1:0]            w_rd_frame;

    logic [LLR_INTERNAL_LEN-1:0]     r_bank [2][N];
    logic [1:0]                      r_full;
    logic                            r_wr_ptr;
    logic                            r_rd_ptr;
    logic [c_cnt_w-1:0]              r_cnt;
    logic                            r_err;
    logic [c_frame_w-1:0]            r_hold;

    // Symmetric clamp keeps the most negative code out of the PE array.
    always_comb begin
        w_shifted = $signed(bus.in_llr) >>> SHIFT;
        w_quant   = w_shifted[LLR_INTERNAL_LEN-1:0];
        if (w_shifted > c_sat_hi) begin
            w_quant = c_sat_hi[LLR_INTERNAL_LEN-1:0];
        end else if (w_shifted < c_sat_lo) begin
            w_quant = c_sat_lo[LLR_INTERNAL_LEN-1:0];
        end
    end

    assign w_in_ready  = !r_full[r_wr_ptr];
    assign w_out_valid = r_full[r_rd_ptr];
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_last_slot = (r_cnt == c_cnt_last);
    assign w_wr_done   = w_in_fire && w_last_slot;
    assign w_rd_done   = w_out_valid && bus.out_ready;

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_ptr] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rd_ptr] = 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_pack
            assign w_rd_frame[i*LLR_INTERNAL_LEN +: LLR_INTERNAL_LEN] = r_bank[r_rd_ptr][i];
        end
    endgenerate

    // Bank contents need no reset: they are only visible behind a full flag.
    always_ff @(posedge clk) begin
        if (!rst && w_in_fire) begin
            r_bank[r_wr_ptr][r_cnt] <= w_quant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                r_cnt <= w_last_slot ? '0 : r_cnt + 1'b1;
                if (bus.in_last != w_last_slot) begin
                    r_err <= 1'b1;
                end
            end
            if (w_wr_done) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_rd_done) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            if (w_out_valid) begin
                r_hold <= w_rd_frame;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_llr   = w_out_valid ? w_rd_frame : r_hold;
    assign bus.frame_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_llr_frame_loader.sv
// ============================================================================
// Module   : tb_llr_frame_loader
// Purpose  : Directed self-checking bench for llr_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_llr_frame_loader;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    llr_frame_loader_if #(.N(8), .CH_W(8), .LLR_INTERNAL_LEN(6)) if0 ();
    llr_frame_loader_if #(.N(8), .CH_W(8), .LLR_INTERNAL_LEN(6)) if1 ();

    llr_frame_loader #(.N(8), .CH_W(8), .SHIFT(0), .LLR_INTERNAL_LEN(6)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    llr_frame_loader #(.N(8), .CH_W(8), .SHIFT(1), .LLR_INTERNAL_LEN(6)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pack(input int v [8]);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*6 +: 6] = 6'(v[i]);
        return r;
    endfunction

    // Holds the value on the bus until accepted, then returns just after that edge.
    task automatic send0(input int v, input bit last);
        int guard;
        guard = 0;
        if0.in_valid = 1'b1;
        if0.in_llr   = 8'(v);
        if0.in_last  = last;
        @(negedge clk);
        while (!if0.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed=in_ready stuck 0 expected=accept within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset0(input string tag);
        rst = 1'b1;
        if0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_in_ready"},  if0.in_ready,  1'b1);
        check({tag, "_out_valid"}, if0.out_valid, 1'b0);
        check({tag, "_out_llr"},   if0.out_llr,   48'h0);
        check({tag, "_frame_err"}, if0.frame_err, 1'b0);
    endtask

    initial begin
        int e [8];
        int v [8];

        rst = 1'b1;
        if0.in_valid = 0; if0.in_llr = 0; if0.in_last = 0; if0.out_ready = 0;
        if1.in_valid = 0; if1.in_llr = 0; if1.in_last = 0; if1.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst1_in_ready",  if1.in_ready,  1'b1);
        check("rst1_out_valid", if1.out_valid, 1'b0);
        check("rst1_out_llr",   if1.out_llr,   48'h0);
        check("rst1_frame_err", if1.frame_err, 1'b0);
        check("rst0_in_ready",  if0.in_ready,  1'b1);
        check("rst0_out_valid", if0.out_valid, 1'b0);

        // Basic frame, SHIFT=1
        v = '{10, -10, 3, -3, 0, 1, -1, 127};
        e = '{5, -5, 1, -2, 0, 0, -1, 31};
        if1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if1.in_valid = 1'b1;
            if1.in_llr   = 8'(v[i]);
            if1.in_last  = (i == 7);
            @(negedge clk);
            if (i == 7) check("basic_pre_valid", if1.out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        if1.in_valid = 1'b0;
        check("basic_out_valid", if1.out_valid, 1'b1);
        check("basic_out_llr",   if1.out_llr,   pack(e));
        check("basic_frame_err", if1.frame_err, 1'b0);
        @(posedge clk);
        #1;
        check("basic_consumed",  if1.out_valid, 1'b0);
        check("basic_hold_llr",  if1.out_llr,   pack(e));

        // Saturation bounds, SHIFT=0
        v = '{-128, -32, -31, 31, 32, 127, -1, 0};
        e = '{-31, -31, -31, 31, 31, 31, -1, 0};
        if0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send0(v[i], i == 7);
        if0.in_valid = 1'b0;
        check("sat_out_valid", if0.out_valid, 1'b1);
        check("sat_out_llr",   if0.out_llr,   pack(e));
        for (int i = 0; i < 8; i++) check("sat_no_m32", if0.out_llr[i*6 +: 6] == 6'b10_0000, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back streaming of four frames
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                e[j] = k*8 + j - 16;
                send0(e[j], j == 7);
                check("stream_in_ready",  if0.in_ready,  1'b1);
                check("stream_out_valid", if0.out_valid, j == 7);
                if (j == 7) check("stream_out_llr", if0.out_llr, pack(e));
            end
        end
        if0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_frame_err", if0.frame_err, 1'b0);

        // Framing error: in_last on the 5th element
        for (int j = 0; j < 8; j++) begin
            e[j] = j;
            send0(j, j == 4);
            check("ferr_flag", if0.frame_err, j >= 4);
        end
        if0.in_valid = 1'b0;
        check("ferr_out_valid", if0.out_valid, 1'b1);
        check("ferr_out_llr",   if0.out_llr,   pack(e));
        repeat (3) @(posedge clk);
        #1;
        check("ferr_sticky", if0.frame_err, 1'b1);
        reset0("ferr_rst");

        // Backpressure: two frames held, input stalls
        if0.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send0(i, (i % 8) == 7);
        for (int j = 0; j < 8; j++) e[j] = j;
        check("bp_in_ready",  if0.in_ready,  1'b0);
        check("bp_out_valid", if0.out_valid, 1'b1);
        check("bp_frame0",    if0.out_llr,   pack(e));
        if0.in_valid = 1'b1;
        if0.in_llr   = 8'd16;
        if0.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stall_ready", if0.in_ready, 1'b0);
        check("bp_stall_llr",   if0.out_llr,  pack(e));
        if0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.out_ready = 1'b0;
        for (int j = 0; j < 8; j++) e[j] = j + 8;
        check("bp_release_ready", if0.in_ready,  1'b1);
        check("bp_release_valid", if0.out_valid, 1'b1);
        check("bp_frame1",        if0.out_llr,   pack(e));
        @(posedge clk);
        #1;
        for (int i = 17; i < 20; i++) send0(i, 1'b0);
        if0.in_valid = 1'b0;
        check("bp_frame1_held", if0.out_llr,   pack(e));
        check("bp_no_ferr",     if0.frame_err, 1'b0);

        // Mid-frame reset
        reset0("mid_rst_a");
        for (int i = 0; i < 3; i++) send0(9, 1'b0);
        if0.in_valid = 1'b0;
        reset0("mid_rst_b");
        for (int j = 0; j < 8; j++) begin
            e[j] = j + 1;
            send0(j + 1, j == 7);
        end
        if0.in_valid = 1'b0;
        check("mid_out_valid", if0.out_valid, 1'b1);
        check("mid_out_llr",   if0.out_llr,   pack(e));
        check("mid_in_ready",  if0.in_ready,  1'b1);
        check("mid_frame_err", if0.frame_err, 1'b0);
        if0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_no_leftover", if0.out_valid, 1'b0);
        check("mid_hold_llr",    if0.out_llr,   pack(e));
        repeat (3) @(posedge clk);
        #1;
        check("mid_still_empty", if0.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
